dma_axi_mc: RTL and testbench

- Multi-channel successor of the single-channel DMA AXI front end.
- N_CH native request ports share one AXI4 master through a round-robin arbiter. Each granted request becomes exactly one INCR read or write burst.
- Sits between accelerator/peripheral native masters and the system AXI interconnect.
- One AXI transaction outstanding at a time. Read or write is selected per request by |wstrb.

---
 rtl/dma_axi_mc.sv | 219 +++++++++++++++++++++
 tb/tb_dma_axi_mc.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_axi_mc.sv
// Multi-channel DMA front end: N_CH native request ports share one AXI4 master through a round-robin arbiter.
// Optional macro DMA_AXI_MC_4K_CHECK_EN refuses bursts that would cross a 4 KiB boundary.
module dma_axi_mc #(
  parameter int N_CH       = 2,
  parameter int DMA_DATA_W = 32,
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_LEN_W  = 8,
  parameter int AXI_ID_W   = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_CH-1:0]                valid,
  input  logic [N_CH*AXI_ADDR_W-1:0]     address,
  input  logic [N_CH*DMA_DATA_W-1:0]     wdata,
  input  logic [N_CH*DMA_DATA_W/8-1:0]   wstrb,
  input  logic [N_CH*AXI_LEN_W-1:0]      dma_len,
  output logic [DMA_DATA_W-1:0]          rdata,
  output logic [N_CH-1:0]                ready,
  output logic [N_CH-1:0]                dma_ready,
  output logic [N_CH-1:0]                error,
  output logic [AXI_ID_W-1:0]            m_axi_arid,
  output logic [AXI_ADDR_W-1:0]          m_axi_araddr,
  output logic [AXI_LEN_W-1:0]           m_axi_arlen,
  output logic [2:0]                     m_axi_arsize,
  output logic [1:0]                     m_axi_arburst,
  output logic                           m_axi_arlock,
  output logic [3:0]                     m_axi_arcache,
  output logic [2:0]                     m_axi_arprot,
  output logic [3:0]                     m_axi_arqos,
  output logic                           m_axi_arvalid,
  input  logic                           m_axi_arready,
  input  logic [AXI_ID_W-1:0]            m_axi_rid,
  input  logic [DMA_DATA_W-1:0]          m_axi_rdata,
  input  logic [1:0]                     m_axi_rresp,
  input  logic                           m_axi_rlast,
  input  logic                           m_axi_rvalid,
  output logic                           m_axi_rready,
  output logic [AXI_ID_W-1:0]            m_axi_awid,
  output logic [AXI_ADDR_W-1:0]          m_axi_awaddr,
  output logic [AXI_LEN_W-1:0]           m_axi_awlen,
  output logic [2:0]                     m_axi_awsize,
  output logic [1:0]                     m_axi_awburst,
  output logic                           m_axi_awlock,
  output logic [3:0]                     m_axi_awcache,
  output logic [2:0]                     m_axi_awprot,
  output logic [3:0]                     m_axi_awqos,
  output logic                           m_axi_awvalid,
  input  logic                           m_axi_awready,
  output logic [DMA_DATA_W-1:0]          m_axi_wdata,
  output logic [DMA_DATA_W/8-1:0]        m_axi_wstrb,
  output logic                           m_axi_wlast,
  output logic                           m_axi_wvalid,
  input  logic                           m_axi_wready,
  input  logic [AXI_ID_W-1:0]            m_axi_bid,
  input  logic [1:0]                     m_axi_bresp,
  input  logic                           m_axi_bvalid,
  output logic                           m_axi_bready
);
  localparam int STRB_W = DMA_DATA_W / 8;
  localparam int IW     = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [2:0] SIZE = 3'($clog2(STRB_W));

  typedef enum logic [2:0] {IDLE, ADDR, RDATA, WDATA, WRESP} state_t;
  state_t state;

  logic [AXI_ADDR_W-1:0] ch_addr  [N_CH];
  logic [DMA_DATA_W-1:0] ch_wdata [N_CH];
  logic [STRB_W-1:0]     ch_strb  [N_CH];
  logic [AXI_LEN_W-1:0]  ch_len   [N_CH];

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    assign ch_addr[g]  = address[g*AXI_ADDR_W +: AXI_ADDR_W];
    assign ch_wdata[g] = wdata[g*DMA_DATA_W +: DMA_DATA_W];
    assign ch_strb[g]  = wstrb[g*STRB_W +: STRB_W];
    assign ch_len[g]   = dma_len[g*AXI_LEN_W +: AXI_LEN_W];
  end

  logic [IW-1:0]         ptr_q, grant_q, sel;
  logic                  found, cross4k, take, rd_err;
  logic [AXI_ADDR_W-1:0] addr_q;
  logic [AXI_LEN_W-1:0]  len_q, beat_q;
  logic                  wr_q;

  // Round-robin search starting one past the last granted channel
  always_comb begin
    logic [IW-1:0] c;
    found = 1'b0;
    sel   = ptr_q;
    c     = '0;
    for (int i = 1; i <= N_CH; i++) begin
      c = IW'((int'(ptr_q) + i) % N_CH);
      if (!found && valid[c]) begin
        found = 1'b1;
        sel   = c;
      end
    end
  end

`ifdef DMA_AXI_MC_4K_CHECK_EN
  logic [31:0] end_off;
  assign end_off = 32'(ch_addr[sel][11:0]) + (32'(ch_len[sel]) + 32'd1) * 32'(STRB_W);
  assign cross4k = end_off > 32'd4096;
`else
  assign cross4k = 1'b0;
`endif

  assign take = (state == IDLE) && found && !cross4k;
  // rlast must land exactly on the final beat; early or missing rlast both count as errors
  assign rd_err = (m_axi_rresp != 2'b00) || (m_axi_rid != AXI_ID_W'(grant_q)) ||
                  (m_axi_rlast != (beat_q == len_q));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      ptr_q         <= IW'(N_CH - 1);
      grant_q       <= '0;
      beat_q        <= '0;
      wr_q          <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_awvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      m_axi_bready  <= 1'b0;
      dma_ready     <= '1;
      error         <= '0;
    end else begin
      case (state)
        // IDLE: grant, or refuse an out-of-range burst in place
        IDLE: if (found) begin
          if (cross4k) begin
            error[sel] <= 1'b1;
          end else begin
            state          <= ADDR;
            grant_q        <= sel;
            ptr_q          <= sel;
            beat_q         <= '0;
            wr_q           <= |ch_strb[sel];
            m_axi_arvalid  <= ~|ch_strb[sel];
            m_axi_awvalid  <= |ch_strb[sel];
            error[sel]     <= 1'b0;
            dma_ready[sel] <= 1'b0;
          end
        end
        ADDR: if ((m_axi_arvalid && m_axi_arready) || (m_axi_awvalid && m_axi_awready)) begin
          m_axi_arvalid <= 1'b0;
          m_axi_awvalid <= 1'b0;
          if (wr_q) begin
            state <= WDATA;
          end else begin
            state        <= RDATA;
            m_axi_rready <= 1'b1;
          end
        end
        RDATA: if (m_axi_rvalid) begin
          if (rd_err) error[grant_q] <= 1'b1;
          beat_q <= beat_q + AXI_LEN_W'(1);
          if (m_axi_rlast) begin
            state              <= IDLE;
            m_axi_rready       <= 1'b0;
            dma_ready[grant_q] <= 1'b1;
          end
        end
        WDATA: if (m_axi_wvalid && m_axi_wready) begin
          beat_q <= beat_q + AXI_LEN_W'(1);
          if (m_axi_wlast) begin
            state        <= WRESP;
            m_axi_bready <= 1'b1;
          end
        end
        WRESP: if (m_axi_bvalid) begin
          if ((m_axi_bresp != 2'b00) || (m_axi_bid != AXI_ID_W'(grant_q))) error[grant_q] <= 1'b1;
          state              <= IDLE;
          m_axi_bready       <= 1'b0;
          dma_ready[grant_q] <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (take) begin
      addr_q <= ch_addr[sel];
      len_q  <= ch_len[sel];
    end
  end

  assign m_axi_arid    = AXI_ID_W'(grant_q);
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = len_q;
  assign m_axi_arsize  = SIZE;
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'd0;
  assign m_axi_arprot  = 3'd0;
  assign m_axi_arqos   = 4'd0;
  assign m_axi_awid    = AXI_ID_W'(grant_q);
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = len_q;
  assign m_axi_awsize  = SIZE;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'd0;
  assign m_axi_awprot  = 3'd0;
  assign m_axi_awqos   = 4'd0;

  // Write beats pass straight through from the granted channel
  assign m_axi_wvalid = (state == WDATA) && valid[grant_q];
  assign m_axi_wdata  = ch_wdata[grant_q];
  assign m_axi_wstrb  = ch_strb[grant_q];
  assign m_axi_wlast  = (state == WDATA) && (beat_q == len_q);
  assign rdata        = m_axi_rdata;

  always_comb begin
    ready = '0;
    if (state == RDATA && m_axi_rvalid) ready[grant_q] = 1'b1;
    if (state == WDATA && m_axi_wvalid && m_axi_wready) ready[grant_q] = 1'b1;
    if (state == IDLE && found && cross4k) ready[sel] = 1'b1;
  end
endmodule

// File: tb/tb_dma_axi_mc.sv
// Bench for dma_axi_mc: directed scenarios and randomized bursts against a round-robin / AXI burst model.
`timescale 1ns/1ps
module tb_dma_axi_mc;
  localparam int N_CH = 2;
  localparam int DW   = 32;
  localparam int AW   = 32;
  localparam int LW   = 8;
  localparam int IDW  = 3;

  logic clk = 1'b0;
  logic rst;
  logic [N_CH-1:0]      valid;
  logic [N_CH*AW-1:0]   address;
  logic [N_CH*DW-1:0]   wdata;
  logic [N_CH*DW/8-1:0] wstrb;
  logic [N_CH*LW-1:0]   dma_len;
  logic [DW-1:0]        rdata;
  logic [N_CH-1:0]      ready, dma_ready, error;
  logic [IDW-1:0] m_axi_arid, m_axi_awid, m_axi_rid, m_axi_bid;
  logic [AW-1:0]  m_axi_araddr, m_axi_awaddr;
  logic [LW-1:0]  m_axi_arlen, m_axi_awlen;
  logic [2:0]     m_axi_arsize, m_axi_awsize, m_axi_arprot, m_axi_awprot;
  logic [1:0]     m_axi_arburst, m_axi_awburst, m_axi_rresp, m_axi_bresp;
  logic           m_axi_arlock, m_axi_awlock;
  logic [3:0]     m_axi_arcache, m_axi_awcache, m_axi_arqos, m_axi_awqos;
  logic           m_axi_arvalid, m_axi_arready, m_axi_awvalid, m_axi_awready;
  logic [DW-1:0]  m_axi_rdata, m_axi_wdata;
  logic [DW/8-1:0] m_axi_wstrb;
  logic           m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic           m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic           m_axi_bvalid, m_axi_bready;

  dma_axi_mc #(.N_CH(N_CH), .DMA_DATA_W(DW), .AXI_ADDR_W(AW), .AXI_LEN_W(LW), .AXI_ID_W(IDW)) dut (
    .clk(clk), .rst(rst), .valid(valid), .address(address), .wdata(wdata), .wstrb(wstrb),
    .dma_len(dma_len), .rdata(rdata), .ready(ready), .dma_ready(dma_ready), .error(error),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int ptr;
  logic [31:0] bd [16];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N_CH-1:0] m, input int p);
    logic [N_CH-1:0] t;
    for (int i = 1; i <= N_CH; i++) begin
      t = m >> ((p + i) % N_CH);
      if (t[0]) return (p + i) % N_CH;
    end
    return -1;
  endfunction

  task automatic set_req(input int ch, input logic [31:0] a, input int len, input bit wr);
    address[ch*AW +: AW]  = a;
    dma_len[ch*LW +: LW]  = LW'(len);
    wstrb[ch*4 +: 4]      = wr ? 4'hF : 4'h0;
    valid                 = valid | (N_CH'(1) << ch);
  endtask

  // Slave side of one burst plus every check on the granted channel
  task automatic serve(input int ch, input bit wr, input int len, input logic [31:0] addr,
                       input int err_beat, input bit bad_id, input bit hold);
    int k, d, guard;
    bit v, g, exp_err;
    logic [N_CH-1:0] onehot;
    onehot  = N_CH'(1) << ch;
    exp_err = (err_beat >= 0) || bad_id;
    @(negedge clk);
    if (!wr) begin
      chk("arvalid", m_axi_arvalid, 1);
      chk("arid", m_axi_arid, ch);
      chk("araddr", m_axi_araddr, addr);
      chk("arlen", m_axi_arlen, len);
      chk("arsize", m_axi_arsize, 2);
      chk("arburst", m_axi_arburst, 1);
      chk("aw_quiet", m_axi_awvalid, 0);
    end else begin
      chk("awvalid", m_axi_awvalid, 1);
      chk("awid", m_axi_awid, ch);
      chk("awaddr", m_axi_awaddr, addr);
      chk("awlen", m_axi_awlen, len);
      chk("awsize", m_axi_awsize, 2);
      chk("awburst", m_axi_awburst, 1);
      chk("ar_quiet", m_axi_arvalid, 0);
    end
    chk("dma_ready_busy", (dma_ready >> ch) & 1, 0);
    chk("err_cleared", (error >> ch) & 1, 0);
    d = $urandom_range(0, 2);
    repeat (d) begin
      @(negedge clk);
      chk("addr_hold", wr ? m_axi_awvalid : m_axi_arvalid, 1);
    end
    m_axi_arready = !wr;
    m_axi_awready = wr;
    @(negedge clk);
    m_axi_arready = 1'b0;
    m_axi_awready = 1'b0;
    chk("addr_drop", m_axi_arvalid | m_axi_awvalid, 0);
    if (!wr) begin
      if (!hold) valid = valid & ~onehot;
      chk("rready_on", m_axi_rready, 1);
      k = 0;
      while (k <= len) begin
        g = ($urandom_range(0, 3) == 0);
        if (g) begin
          m_axi_rvalid = 1'b0;
          #1 chk("rd_gap_ready", ready, 0);
        end else begin
          m_axi_rvalid = 1'b1;
          m_axi_rdata  = bd[k];
          m_axi_rresp  = (k == err_beat) ? 2'b10 : 2'b00;
          m_axi_rlast  = (k == len);
          m_axi_rid    = (bad_id && k == 0) ? IDW'(ch ^ 1) : IDW'(ch);
          #1;
          chk("rd_ready", ready, onehot);
          chk("rdata", rdata, bd[k]);
          k++;
        end
        @(negedge clk);
      end
      m_axi_rvalid = 1'b0;
      m_axi_rlast  = 1'b0;
      m_axi_rresp  = 2'b00;
      chk("rready_off", m_axi_rready, 0);
    end else begin
      k = 0;
      guard = 0;
      while (k <= len && guard < 200) begin
        v = hold ? 1'b1 : ($urandom_range(0, 3) != 0);
        g = ($urandom_range(0, 3) != 0);
        valid = v ? (valid | onehot) : (valid & ~onehot);
        wdata[ch*DW +: DW] = bd[k];
        m_axi_wready = g;
        #1;
        chk("wvalid", m_axi_wvalid, v);
        chk("wr_ready", ready, (v && g) ? onehot : '0);
        if (v) begin
          chk("wdata", m_axi_wdata, bd[k]);
          chk("wstrb", m_axi_wstrb, 4'hF);
          chk("wlast", m_axi_wlast, (k == len));
        end
        if (v && g) k++;
        guard++;
        @(negedge clk);
      end
      chk("wr_beats_done", (k > len), 1);
      m_axi_wready = 1'b0;
      valid = hold ? (valid | onehot) : (valid & ~onehot);
      chk("bready_on", m_axi_bready, 1);
      chk("wvalid_off", m_axi_wvalid, 0);
      d = $urandom_range(0, 2);
      repeat (d) begin
        @(negedge clk);
        chk("bready_hold", m_axi_bready, 1);
      end
      m_axi_bvalid = 1'b1;
      m_axi_bresp  = (err_beat >= 0) ? 2'b10 : 2'b00;
      m_axi_bid    = bad_id ? IDW'(ch ^ 1) : IDW'(ch);
      @(negedge clk);
      m_axi_bvalid = 1'b0;
      m_axi_bresp  = 2'b00;
      chk("bready_off", m_axi_bready, 0);
    end
    chk("dma_ready_back", dma_ready, {N_CH{1'b1}});
    chk("err_result", (error >> ch) & 1, exp_err);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    logic [N_CH-1:0] m;
    int c, ln, eb;
    bit bid_bad;
    bit          wr_r   [N_CH];
    int          len_r  [N_CH];
    logic [31:0] addr_r [N_CH];

    rst = 1'b1;
    valid = '0; address = '0; wdata = '0; wstrb = '0; dma_len = '0;
    m_axi_arready = 0; m_axi_awready = 0; m_axi_wready = 0;
    m_axi_rid = '0; m_axi_rdata = '0; m_axi_rresp = '0; m_axi_rlast = 0; m_axi_rvalid = 0;
    m_axi_bid = '0; m_axi_bresp = '0; m_axi_bvalid = 0;
    repeat (2) @(negedge clk);
    chk("rst_arvalid", m_axi_arvalid, 0);
    chk("rst_awvalid", m_axi_awvalid, 0);
    chk("rst_wvalid", m_axi_wvalid, 0);
    chk("rst_rready", m_axi_rready, 0);
    chk("rst_bready", m_axi_bready, 0);
    chk("rst_ready", ready, 0);
    chk("rst_error", error, 0);
    chk("rst_dma_ready", dma_ready, {N_CH{1'b1}});
    rst = 1'b0;
    ptr = N_CH - 1;

    // ch0 read of four beats
    for (int i = 0; i < 4; i++) bd[i] = 32'hA0 + i;
    set_req(0, 32'h1000, 3, 0);
    c = rr_pick(valid, ptr); ptr = c;
    serve(c, 0, 3, 32'h1000, -1, 0, 0);
    valid = '0;

    // ch1 write of two beats
    bd[0] = 32'h11; bd[1] = 32'h22;
    set_req(1, 32'h2000, 1, 1);
    c = rr_pick(valid, ptr); ptr = c;
    serve(c, 1, 1, 32'h2000, -1, 0, 0);
    valid = '0;

    // SLVERR on beat 2 of 4, then a clean ch0 burst clears the flag
    for (int i = 0; i < 4; i++) bd[i] = $urandom;
    set_req(0, 32'h1100, 3, 0);
    c = rr_pick(valid, ptr); ptr = c;
    serve(c, 0, 3, 32'h1100, 1, 0, 0);
    valid = '0;
    for (int i = 0; i < 4; i++) bd[i] = $urandom;
    set_req(0, 32'h1200, 0, 0);
    c = rr_pick(valid, ptr); ptr = c;
    serve(c, 0, 0, 32'h1200, -1, 0, 0);
    valid = '0;

    // fresh reset, both channels held: grants go 0, 1, 0
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; ptr = N_CH - 1;
    set_req(0, 32'h5000, 1, 0);
    set_req(1, 32'h6000, 2, 0);
    for (int i = 0; i < 4; i++) bd[i] = $urandom;
    serve(0, 0, 1, 32'h5000, -1, 0, 1);
    serve(1, 0, 2, 32'h6000, -1, 0, 1);
    serve(0, 0, 1, 32'h5000, -1, 0, 1);
    ptr = 0;
    valid = '0;

    // reset during the second read beat
    @(negedge clk);
    set_req(0, 32'h3000, 3, 0);
    @(negedge clk);
    chk("rst_t_ar", m_axi_arvalid, 1);
    m_axi_arready = 1'b1;
    @(negedge clk);
    m_axi_arready = 1'b0;
    valid = '0;
    m_axi_rvalid = 1'b1; m_axi_rdata = 32'hC0; m_axi_rlast = 1'b0; m_axi_rid = '0; m_axi_rresp = 2'b00;
    #1 chk("rst_t_beat0", ready, 1);
    @(negedge clk);
    m_axi_rdata = 32'hC1;
    #1 chk("rst_t_beat1", ready, 1);
    rst = 1'b1;
    #1;
    chk("rst_t_rready", m_axi_rready, 0);
    chk("rst_t_ready", ready, 0);
    chk("rst_t_arvalid", m_axi_arvalid, 0);
    chk("rst_t_awvalid", m_axi_awvalid, 0);
    chk("rst_t_wvalid", m_axi_wvalid, 0);
    chk("rst_t_bready", m_axi_bready, 0);
    chk("rst_t_dma_ready", dma_ready, {N_CH{1'b1}});
    chk("rst_t_error", error, 0);
    m_axi_rvalid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    ptr = N_CH - 1;
    for (int i = 0; i < 4; i++) bd[i] = $urandom;
    set_req(0, 32'h3000, 3, 0);
    c = rr_pick(valid, ptr); ptr = c;
    serve(c, 0, 3, 32'h3000, -1, 0, 0);
    valid = '0;

    // randomized contention, directions, lengths and response faults
    for (int it = 0; it < 20; it++) begin
      m = N_CH'($urandom_range(1, (1 << N_CH) - 1));
      for (int ch = 0; ch < N_CH; ch++) begin
        wr_r[ch]   = 1'($urandom_range(0, 1));
        len_r[ch]  = $urandom_range(0, 7);
        addr_r[ch] = 32'h4000_0000 | (32'(ch) << 12) | (32'($urandom_range(0, 63)) << 2);
        if (((m >> ch) & 1) != 0) set_req(ch, addr_r[ch], len_r[ch], wr_r[ch]);
      end
      c = rr_pick(m, ptr); ptr = c;
      ln = len_r[c];
      for (int i = 0; i < 16; i++) bd[i] = $urandom;
      eb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, ln) : -1;
      bid_bad = ($urandom_range(0, 7) == 0);
      serve(c, wr_r[c], ln, addr_r[c], eb, bid_bad, 0);
      valid = '0;
    end

`ifdef DMA_AXI_MC_4K_CHECK_EN
    @(negedge clk);
    set_req(0, 32'h0000_0FF8, 3, 0);
    #1 chk("4k_ready_pulse", ready, 1);
    @(negedge clk);
    valid = '0;
    chk("4k_no_ar", m_axi_arvalid, 0);
    chk("4k_err", error & 1, 1);
    chk("4k_dma_ready", dma_ready & 1, 1);
    #1 chk("4k_ready_gone", ready, 0);
    for (int i = 0; i < 4; i++) bd[i] = $urandom;
    set_req(0, 32'h0000_0FF0, 3, 0);
    serve(0, 0, 3, 32'h0000_0FF0, -1, 0, 0);
    ptr = 0;
    valid = '0;
`endif

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
